// File: rtl/shift_pkg.sv
// Shared definitions for the shift pipeline: default widths and the op encoding
// used on in_op.
package shift_pkg;

    localparam int N_DEF = 16;
    localparam int C_DEF = 4;

    typedef enum logic [1:0] {
        OP_SRA = 2'b00,
        OP_SRL = 2'b01,
        OP_SLL = 2'b10,
        OP_ROR = 2'b11
    } shift_op_e;

endpackage

// File: rtl/shift_core.sv
// Combinational N-bit shifter: log2(N) right-shift mux layers with a per-layer fill.
// SLL reuses the right-shift path between two bit reversals.
module shift_core
    import shift_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int C = C_DEF
) (
    input  logic [N-1:0] data_i,
    input  logic [C-1:0] cnt_i,
    input  logic [1:0]   op_i,
    output logic [N-1:0] res_o
);

    function automatic logic [N-1:0] bit_rev(input logic [N-1:0] v);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[i] = v[N-1-i];
        end
        return r;
    endfunction

    logic         is_sll;
    logic         is_ror;
    logic         fill_bit;
    logic [N-1:0] layer [C+1];

    assign is_sll   = (op_i == OP_SLL);
    assign is_ror   = (op_i == OP_ROR);
    assign fill_bit = (op_i == OP_SRA) && data_i[N-1];
    assign layer[0] = is_sll ? bit_rev(data_i) : data_i;

    // Layer k shifts by 2**k; ROR wraps the bits shifted out back into the top.
    for (genvar k = 0; k < C; k++) begin : g_layer
        localparam int S = 1 << k;
        logic [S-1:0] fill;
        always_comb begin
            fill = is_ror ? layer[k][S-1:0] : {S{fill_bit}};
        end
        assign layer[k+1] = cnt_i[k] ? {fill, layer[k][N-1:S]} : layer[k];
    end

    assign res_o = is_sll ? bit_rev(layer[C]) : layer[C];

endmodule

// File: rtl/shift_pipe.sv
// Two-stage elastic shift unit: stage A holds operands, stage B holds the result.
// Full backpressure; in_ready depends combinationally on out_ready only.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int C = C_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [C-1:0] in_cnt,
    input  logic [1:0]   in_op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_zero
);

    logic         vld_p0_q, vld_p0_d;
    logic [N-1:0] data_p0_q, data_p0_d;
    logic [C-1:0] cnt_p0_q, cnt_p0_d;
    logic [1:0]   op_p0_q, op_p0_d;

    logic         vld_p1_q, vld_p1_d;
    logic [N-1:0] res_p1_q, res_p1_d;
    logic         zero_p1_q, zero_p1_d;

    logic         a_adv;
    logic         accept;
    logic [N-1:0] core_res;

    assign a_adv    = vld_p0_q && (!vld_p1_q || out_ready);
    assign in_ready = !vld_p0_q || a_adv;
    assign accept   = in_valid && in_ready;

    shift_core #(.N(N), .C(C)) u_core (
        .data_i (data_p0_q),
        .cnt_i  (cnt_p0_q),
        .op_i   (op_p0_q),
        .res_o  (core_res)
    );

    // Stage A: operand register
    always_comb begin
        vld_p0_d  = vld_p0_q;
        data_p0_d = data_p0_q;
        cnt_p0_d  = cnt_p0_q;
        op_p0_d   = op_p0_q;
        if (flush) begin
            vld_p0_d = 1'b0;
        end else if (accept) begin
            vld_p0_d  = 1'b1;
            data_p0_d = in_data;
            cnt_p0_d  = in_cnt;
            op_p0_d   = in_op;
        end else if (!(vld_p0_q && !a_adv)) begin
            vld_p0_d = 1'b0;
        end
    end

    // Stage B: result register
    always_comb begin
        vld_p1_d  = vld_p1_q;
        res_p1_d  = res_p1_q;
        zero_p1_d = zero_p1_q;
        if (flush) begin
            vld_p1_d = 1'b0;
        end else if (a_adv) begin
            vld_p1_d  = 1'b1;
            res_p1_d  = core_res;
            zero_p1_d = (core_res == '0);
        end else if (out_ready) begin
            vld_p1_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0_q  <= 1'b0;
            data_p0_q <= '0;
            cnt_p0_q  <= '0;
            op_p0_q   <= '0;
            vld_p1_q  <= 1'b0;
            res_p1_q  <= '0;
            zero_p1_q <= 1'b0;
        end else begin
            vld_p0_q  <= vld_p0_d;
            data_p0_q <= data_p0_d;
            cnt_p0_q  <= cnt_p0_d;
            op_p0_q   <= op_p0_d;
            vld_p1_q  <= vld_p1_d;
            res_p1_q  <= res_p1_d;
            zero_p1_q <= zero_p1_d;
        end
    end

    assign out_valid = vld_p1_q;
    assign out_data  = res_p1_q;
    assign out_zero  = zero_p1_q;

endmodule

// File: doc/shift_pipe.md
# shift_pipe

Two-stage elastic shift unit for the execute stage. It accepts operands from decode through a valid/ready handshake and computes the shift or rotate in a combinational 16-bit core. The registered result goes downstream to the writeback mux with full backpressure support. It sustains one operation per cycle, with a fixed 2-cycle latency when unstalled.

## Interface
- `N`, 16: data width; must be a power of two.
- `C`, 4: shift-count width; equals log2(N).
- `clk` in 1: sole clock; every register updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `flush` in 1: synchronous squash of all in-flight operations (branch mispredict).
- `in_valid` in 1: operand bundle presented.
- `in_ready` out 1: stage A can accept this cycle.
- `in_data` in N: value to shift.
- `in_cnt` in C: shift amount, 0..N-1.
- `in_op` in 2: 00 SRA, 01 SRL, 10 SLL, 11 ROR.
- `out_valid` out 1: result held in stage B.
- `out_ready` in 1: consumer takes the result this cycle.
- `out_data` out N: shifted result.
- `out_zero` out 1: `out_data == 0`; registered alongside `out_data`.

## Operation
- Stage A register holds `a_valid`, data, cnt and op.
  - Loads on `in_valid && in_ready`.
  - Otherwise holds while `a_valid && !a_adv`.
  - Otherwise clears.
- `a_adv = a_valid && (!b_valid || out_ready)`.
- `in_ready = !a_valid || a_adv`. This is combinational on `out_ready`, so throughput is full.
- Stage B register holds `b_valid`, result and zero flag.
  - Loads core output on `a_adv`.
  - Clears `b_valid` on `out_ready && !a_adv`.
  - Otherwise holds.
- Core arithmetic, all on N bits; no bits beyond N are ever produced:
  - SRA: fill with `data[N-1]`.
  - SRL: fill with 0.
  - SLL: reverse bits, shift right with 0-fill, reverse again.
  - ROR: `(data >> cnt) | (data << (N-cnt))`, with cnt=0 giving data unchanged.
- cnt=0 passes data through unchanged for every op.
- `out_data` and `out_zero` are don't-care while `out_valid=0`. Bench checks them only when valid.
- Flush:
  - `flush=1` clears `a_valid` and `b_valid` next edge.
  - Flush takes priority over a same-cycle accept and a same-cycle advance.
  - An `in_valid` presented during flush is dropped; `in_ready` stays as computed.
- Reset: `rst_n=0` at an edge clears `a_valid` and `b_valid` and zeroes data/result registers. Reset takes priority over flush and handshakes.
- Mid-operation reset discards all in-flight work. No output handshake completes on that edge.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_zero=0`, `in_ready=1`.
- Latency: an op accepted at edge k gives `out_valid=1` after edge k+1, if stage B is free.
- Throughput: 1 op/cycle with `out_ready` held high.
- Backpressure with `out_ready=0` and B full:
  - A holds and `in_ready` = `!a_valid`.
  - At most 2 ops are buffered.
- Simultaneous `out_ready` with B and A full: B reloads from A and A accepts a new op, both on the same edge.
- `out_data` and `out_valid` are stable while `out_valid && !out_ready`.
- No combinational path from `in_*` to `out_*`. The only combinational input-to-output path is `out_ready` to `in_ready`.

## Structure
- Shared package `shift_pkg`:
  - op encoding constants `OP_SRA`, `OP_SRL`, `OP_SLL`, `OP_ROR`.
  - width defaults N=16, C=4.
- Sub-module `shift_core` (combinational; data, cnt and op in, result out).
  - Built as log2(N) mux layers of 1/2/4/8 with per-layer fill select.
  - Bit reversal for SLL.
  - Wrap fill for ROR.
- `shift_pipe` contains only the two register stages, the handshake logic and the zero detect.

## Test plan
- Reset then single ops with `out_ready=1`:
  - SRA 0x8001 cnt 1 -> 0xC000.
  - SRL 0x8001 cnt 4 -> 0x0800.
  - SLL 0x0001 cnt 15 -> 0x8000.
  - ROR 0x0001 cnt 1 -> 0x8000.
  - Each appears 2 cycles after accept.
- Zero/boundary checks:
  - SRL 0x00FF cnt 8 -> 0x0000 with `out_zero=1`.
  - ROR 0xABCD cnt 0 -> 0xABCD.
  - SRA 0x7FFF cnt 15 -> 0x0000.
- Streaming: 8 back-to-back ops with `out_ready=1` -> `in_ready` is never low, and results arrive in order, one per cycle.
- Backpressure:
  - `out_ready=0` after 2 accepts -> `in_ready=0`, and `out_data` is held stable for 5 cycles.
  - Release -> both results drain in order with no loss or duplication.
- Flush with A and B full plus `in_valid=1` -> next cycle `out_valid=0`, and the flushed ops and the dropped input never appear.
- Drive `rst_n=0` for one edge with ops in flight -> `out_valid=0`, `out_data=0` and `in_ready=1` next cycle, and the pipeline resumes normally afterwards.
